// File: rtl/cpu_clock_reset_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_clock_reset_seq_if
// Bundle of the control/status signals exchanged between the clock-enable and
// reset sequencer and the rest of the 6502 system.
//
// Parameter:
//   N_DOMAINS       width of rst_out; must equal the sequencer's N_DOMAINS.
//
// Signals:
//   soft_reset_req  system -> sequencer  level request to restart the sequence
//   cpu_en          sequencer -> system  one-clk CPU cycle enable
//   phi0            sequencer -> system  CPU phase-0 level
//   long_cycle      sequencer -> system  current CPU cycle is stretched
//   rst_out         sequencer -> system  active-high per-domain resets
//   ready           sequencer -> system  every domain released
//
// Modports:
//   master  the sequencer side
//   slave   the consumer side (CPU core, memories, video, I/O)
// -----------------------------------------------------------------------------
interface cpu_clock_reset_seq_if #(
    parameter int N_DOMAINS = 4
);
    logic                 soft_reset_req;
    logic                 cpu_en;
    logic                 phi0;
    logic                 long_cycle;
    logic [N_DOMAINS-1:0] rst_out;
    logic                 ready;

    modport master (
        input  soft_reset_req,
        output cpu_en,
        output phi0,
        output long_cycle,
        output rst_out,
        output ready
    );

    modport slave (
        output soft_reset_req,
        input  cpu_en,
        input  phi0,
        input  long_cycle,
        input  rst_out,
        input  ready
    );
endinterface

// File: rtl/cpu_clock_reset_seq.sv
// -----------------------------------------------------------------------------
// cpu_clock_reset_seq
// Divides the 14.318 MHz master clock into a one-clk CPU cycle enable and a
// phase-0 level, and sequences the system resets: all domains are held for
// HOLD_CYCLES CPU cycles, then released one per CPU cycle, bit 0 first.
//
// Optional feature macro: CPU_CLK_STRETCH_EN
//   defined   - the last CPU cycle of every STRETCH_PERIOD-cycle frame is
//               STRETCH_CLKS master clocks longer (phi0 high phase stretched).
//   undefined - every CPU cycle is DIV clocks, long_cycle is tied to 0.
//
// Ports:
//   clk      in   master clock
//   reset_n  in   asynchronous active-low reset
//   bus      cpu_clock_reset_seq_if.master
//            soft_reset_req in, cpu_en/phi0/long_cycle/rst_out/ready out
// -----------------------------------------------------------------------------
module cpu_clock_reset_seq #(
    parameter int DIV            = 14,
    parameter int STRETCH_PERIOD = 65,
    parameter int STRETCH_CLKS   = 2,
    parameter int HOLD_CYCLES    = 3,
    parameter int N_DOMAINS      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    cpu_clock_reset_seq_if.master        bus
);

    if (DIV < 2 || (DIV % 2) != 0 || STRETCH_CLKS < 1 || STRETCH_PERIOD < 1 ||
        HOLD_CYCLES < 1 || N_DOMAINS < 1) begin : g_param_check
        $error("cpu_clock_reset_seq: illegal parameter set");
    end

    localparam int MCNT_W = $clog2(DIV + STRETCH_CLKS);
    localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int K_W    = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [MCNT_W-1:0] LAST_NORM  = MCNT_W'(DIV - 1);
    localparam logic [MCNT_W-1:0] PHI_START  = MCNT_W'(DIV / 2);
    localparam logic [HCNT_W-1:0] HCNT_LAST  = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [K_W-1:0]    K_LAST     = K_W'(N_DOMAINS - 1);

    logic [MCNT_W-1:0] mcnt, mcnt_nx, last_nx;
    logic              cpu_en_r, phi0_r;

    // cpu_en_r is high exactly while mcnt sits on the last count of the
    // cycle, so it doubles as the wrap condition for every counter.
    assign mcnt_nx = cpu_en_r ? '0 : mcnt + MCNT_W'(1);

`ifdef CPU_CLK_STRETCH_EN
    localparam int CCNT_W = (STRETCH_PERIOD > 1) ? $clog2(STRETCH_PERIOD) : 1;
    localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(STRETCH_PERIOD - 1);
    localparam logic [MCNT_W-1:0] LAST_LONG = MCNT_W'(DIV + STRETCH_CLKS - 1);

    logic [CCNT_W-1:0] ccnt, ccnt_nx;
    logic              long_r, long_nx;

    // Next-state length is needed so the registered cpu_en lines up with
    // the cycle that is about to start (long or normal).
    always_comb begin
        ccnt_nx = ccnt;
        if (cpu_en_r) begin
            ccnt_nx = (ccnt == CCNT_LAST) ? '0 : ccnt + CCNT_W'(1);
        end
        long_nx = (ccnt_nx == CCNT_LAST);
        last_nx = long_nx ? LAST_LONG : LAST_NORM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccnt   <= '0;
            long_r <= 1'b0;
        end else begin
            ccnt   <= ccnt_nx;
            long_r <= long_nx;
        end
    end

    assign bus.long_cycle = long_r;
`else
    assign last_nx        = LAST_NORM;
    assign bus.long_cycle = 1'b0;
`endif

    // Divider: outputs are registered from next-state count so they are
    // aligned with mcnt itself rather than one clk late.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt     <= '0;
            cpu_en_r <= 1'b0;
            phi0_r   <= 1'b0;
        end else begin
            mcnt     <= mcnt_nx;
            cpu_en_r <= (mcnt_nx == last_nx);
            phi0_r   <= (mcnt_nx >= PHI_START);
        end
    end

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 state;
    logic [HCNT_W-1:0]      hcnt;
    logic [K_W-1:0]         k;
    logic [N_DOMAINS-1:0]   rst_r;
    logic                   ready_r;

    // Soft reset has priority over a coincident cpu_en so that pulse is not
    // counted toward the hold. Domains are released lowest bit first, so
    // clearing rst_out[k] is the same as shifting a zero in from the bottom.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_HOLD;
            hcnt    <= '0;
            k       <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
        end else if (bus.soft_reset_req) begin
            state   <= S_HOLD;
            hcnt    <= '0;
            k       <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
        end else if (cpu_en_r) begin
            case (state)
                S_HOLD: begin
                    if (hcnt == HCNT_LAST) begin
                        state <= S_RELEASE;
                        hcnt  <= '0;
                        k     <= '0;
                    end else begin
                        hcnt  <= hcnt + HCNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    rst_r <= rst_r << 1;
                    if (k == K_LAST) begin
                        state   <= S_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state   <= S_HOLD;
                    hcnt    <= '0;
                    k       <= '0;
                    rst_r   <= '1;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_en  = cpu_en_r;
    assign bus.phi0    = phi0_r;
    assign bus.rst_out = rst_r;
    assign bus.ready   = ready_r;

endmodule

// File: doc/cpu_clock_reset_seq.md
# cpu_clock_reset_seq

Parametrised clock-enable and reset sequencer for the 6502 system: it divides the 14.318 MHz master clock into a CPU cycle enable and a phase-0 level, and it runs a power-on/soft reset sequence. That sequence holds a configurable number of reset domains (CPU, RAM, video, I/O) in reset, then releases them one at a time on CPU-cycle boundaries. It sits at the top level beside the CPU core and replaces ad-hoc bench reset pulsing with a synthesizable reset sequence.

## Interface
- `DIV`, 14: master clocks per normal CPU cycle; must be even and ≥ 2.
- `STRETCH_PERIOD`, 65: CPU cycles per stretch frame; the last cycle of each frame is long.
- `STRETCH_CLKS`, 2: extra master clocks added to a long cycle; must be ≥ 1.
- `HOLD_CYCLES`, 3: CPU cycles during which all domains are held in reset; must be ≥ 1.
- `N_DOMAINS`, 4: number of reset outputs; must be ≥ 1.

- `clk`  in  1  master clock; the single clock of the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `soft_reset_req`  in  1  synchronous request to restart the reset sequence; level-sensitive, sampled every clk.
- `cpu_en`  out  1  one-clk-wide CPU cycle enable (registered).
- `phi0`  out  1  CPU phase-0 level (registered).
- `long_cycle`  out  1  high throughout a stretched CPU cycle.
- `rst_out`  out  N_DOMAINS  active-high per-domain resets; bit 0 is released first.
- `ready`  out  1  high once every domain is released.

## Operation
- Master counter `mcnt`:
  - Width `$clog2(DIV+STRETCH_CLKS)`.
  - Cycle length `len` = `DIV`, or `DIV+STRETCH_CLKS` when `long_cycle`=1.
  - Increments every clk and wraps to 0 after `len-1`.
- Outputs driven from `mcnt`:
  - `cpu_en`=1 while `mcnt==len-1`.
  - `phi0`=1 while `mcnt>=DIV/2`, so a long cycle stretches the high phase.
- Cycle counter `ccnt`:
  - Width `$clog2(STRETCH_PERIOD)`.
  - Increments on the edge that ends a `cpu_en` pulse and wraps to 0 after `STRETCH_PERIOD-1`.
  - `long_cycle`=1 while `ccnt==STRETCH_PERIOD-1`.
- `mcnt` and `ccnt` run continuously from reset release. Soft reset never touches them.
- State machine:
  - HOLD: `rst_out`=all ones, `ready`=0. Counts `cpu_en` pulses in `hcnt`. On the edge ending pulse number `HOLD_CYCLES`, go to RELEASE with index `k`=0.
  - RELEASE: on the edge ending each `cpu_en` pulse, clear `rst_out[k]` and increment `k`. On the edge that clears bit `N_DOMAINS-1`, go to RUN and set `ready`=1 on that same edge.
  - RUN: `rst_out`=0, `ready`=1. Stays here until a soft reset.
- Soft reset: `soft_reset_req`=1 in any state has the following effect on the next edge:
  - `rst_out` goes to all ones and `ready` to 0.
  - The state machine goes to HOLD with `hcnt`=0 and `k`=0.
  - Holding the request high keeps the block in HOLD with `hcnt` held at 0.
- Simultaneous `cpu_en` end and `soft_reset_req`: the soft reset wins, and the pulse is not counted toward the hold.
- Async reset (`reset_n`=0), taking effect immediately at any time, including mid-sequence:
  - `mcnt`=0, `ccnt`=0, state HOLD, `hcnt`=0, `k`=0.
  - `cpu_en`=0, `phi0`=0, `long_cycle`=0, `rst_out`=all ones, `ready`=0.

## Timing
- Edges are numbered from 1, starting at the first rising edge with `reset_n` high.
- Without stretch, the k-th `cpu_en` pulse occupies the period that ends at edge `k·DIV`.
- `rst_out[i]` falls at the edge ending pulse `HOLD_CYCLES+1+i`.
- `ready` rises at the edge ending pulse `HOLD_CYCLES+N_DOMAINS`.
- Soft reset latency is 1 clk. The release sequence restarts a full `HOLD_CYCLES` after the request drops.
- `rst_out`, `ready`, and `long_cycle` change only on the edge ending a `cpu_en` pulse. The exceptions are async reset and soft reset.

## Configuration
- `CPU_CLK_STRETCH_EN` defined:
  - Long cycles are generated as described above.
- Undefined:
  - `ccnt` and the stretch logic are removed.
  - `long_cycle` is tied to 0.
  - Every cycle is `DIV` clocks long.
  - `STRETCH_PERIOD` and `STRETCH_CLKS` are ignored.

## Test plan
- Default parameters, reset_n low for 3 clk then high:
  - `cpu_en` pulses at edges 14, 28, 42, …
  - `phi0` is high for `mcnt` 7..13.
  - `rst_out` bit 0 falls at edge 56, bit 1 at 70, bit 2 at 84, bit 3 at 98.
  - `ready` rises at 98.
- `CPU_CLK_STRETCH_EN` defined, defaults:
  - Pulse 65 ends at edge 912 and is 16 clks long, with `phi0` high for 9 clks.
  - Pulse 66 ends at edge 926.
  - The pattern repeats every 65 cycles.
- Macro undefined:
  - Pulse 65 ends at edge 910, and `long_cycle` stays 0 throughout.
- `soft_reset_req` held 1 clk at edge 500 while in RUN:
  - `rst_out`=4'hF and `ready`=0 after edge 501.
  - `cpu_en` cadence is unchanged.
  - Bit 0 is released 4 pulse-ends later.
- `reset_n` pulsed low mid-RELEASE, after bit 0 is already cleared:
  - All outputs immediately take their reset values.
  - The sequence restarts exactly as in scenario 1.
- `N_DOMAINS=1`, `HOLD_CYCLES=1`, `DIV=2`:
  - `cpu_en` pulses every 2 clks.
  - `rst_out` falls and `ready` rises together at edge 4.
